// File: rtl/instruction_fetch.sv
// Instruction fetch stage: advances the PC, issues single-cycle imem reads and queues
// PC-tagged instructions in a small FIFO for decode, flushing on execute redirects.
`timescale 1ns/1ps

module instruction_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] fifo_instr [DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [DATA_W-1:0] hold_instr;
    logic [ADDR_W-1:0] hold_pc;

    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;

    // Reserve a FIFO slot for every outstanding read so a response can never overflow.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign imem_addr = {pc[ADDR_W-1:2], 2'b00};
    assign imem_req  = !clr && !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
    assign pc_en     = !clr && (imem_req || redirect);
    assign pc_next   = redirect ? {redirect_pc[ADDR_W-1:2], 2'b00} : imem_addr + ADDR_W'(4);

    assign if_valid  = (count != '0);
    assign push      = inflight && !redirect;
    assign pop       = if_valid && if_ready;

    // When empty, present the last head value rather than whatever stale slot rd_ptr hits.
    assign if_instr  = if_valid ? fifo_instr[rd_ptr] : hold_instr;
    assign if_pc     = if_valid ? fifo_pc[rd_ptr]    : hold_pc;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= imem_addr;
            end
            if (if_valid) begin
                hold_instr <= fifo_instr[rd_ptr];
                hold_pc    <= fifo_pc[rd_ptr];
            end
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= inflight_pc;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC model, a 1-cycle memory model and a
// scoreboard of issued addresses checked against every decode handshake.
`timescale 1ns/1ps

module tb_instruction_fetch;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk;
    logic        clr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic [31:0] pc_init;
    logic [31:0] exp_q[$];
    int          checks;
    int          failures;
    int          nreq;

    instruction_fetch #(
        .ADDR_W(32),
        .DATA_W(32),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .pc         (pc),
        .pc_next    (pc_next),
        .pc_en      (pc_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge clr) begin
        if (clr) pc <= pc_init;
        else if (pc_en) pc <= pc_next;
    end

    always @(posedge clk) imem_rdata <= imem_addr ^ MAGIC;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: issued addresses in order; accepted words must match the front entry.
    always @(negedge clk) begin
        logic [31:0] e;
        if (clr) begin
            exp_q.delete();
        end else begin
            if (if_valid && if_ready) begin
                chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_if_pc", if_pc, e);
                    chk("sb_if_instr", if_instr, e ^ MAGIC);
                end
            end
            if (redirect) exp_q.delete();
            if (imem_req) begin
                chk("imem_addr_align", imem_addr, {pc[31:2], 2'b00});
                exp_q.push_back(imem_addr);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic reset_to(input logic [31:0] p);
        @(posedge clk);
        #1;
        pc_init = p;
        clr     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        pc_init     = 32'h0;
        clr         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = 1'b1;

        // Reset state and start-up latency.
        smp();
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        smp();
        chk("c1_pc_en", 32'(pc_en), 32'd1);
        chk("c1_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("c2_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("c3_if_valid", 32'(if_valid), 32'd1);
        chk("c3_if_pc", if_pc, 32'h0);
        nxt(); smp();
        chk("c4_if_pc", if_pc, 32'h4);
        nxt(); smp();
        chk("c5_if_pc", if_pc, 32'h8);
        chk("c5_if_instr", if_instr, 32'h8 ^ MAGIC);

        // Backpressure from the start.
        if_ready = 1'b0;
        reset_to(32'h0);
        nreq = 0;
        for (int c = 1; c <= 8; c++) begin
            smp();
            if (imem_req) nreq++;
            if (c >= 3) begin
                chk("bp_if_valid", 32'(if_valid), 32'd1);
                chk("bp_if_pc", if_pc, 32'h0);
            end
            nxt();
        end
        chk("bp_nreq", 32'(nreq), 32'd4);
        chk("bp_pc_hold", pc, 32'h10);
        chk("bp_pc_en", 32'(pc_en), 32'd0);
        if_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("drain_if_pc", if_pc, 32'(k * 4));
            nxt();
        end

        // Redirect with three buffered and one in flight.
        if_ready = 1'b0;
        reset_to(32'h0);
        repeat (4) nxt();
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        smp();
        chk("rd_pc_next", pc_next, 32'h200);
        chk("rd_imem_req", 32'(imem_req), 32'd0);
        chk("rd_pc_en", 32'(pc_en), 32'd1);
        chk("rd_if_valid", 32'(if_valid), 32'd1);
        nxt();
        redirect = 1'b0;
        if_ready = 1'b1;
        smp();
        chk("rd1_if_valid", 32'(if_valid), 32'd0);
        chk("rd1_imem_addr", imem_addr, 32'h200);
        chk("rd1_imem_req", 32'(imem_req), 32'd1);
        nxt(); smp();
        chk("rd2_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("rd3_if_valid", 32'(if_valid), 32'd1);
        chk("rd3_if_pc", if_pc, 32'h200);
        chk("rd3_if_instr", if_instr, 32'h200 ^ MAGIC);

        // Redirect while a response arrives and decode pops.
        nxt(); nxt();
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        smp();
        chk("rp_if_valid", 32'(if_valid), 32'd1);
        chk("rp_if_pc", if_pc, 32'h208);
        nxt();
        redirect = 1'b0;
        smp();
        chk("rp1_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("rp2_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("rp3_if_pc", if_pc, 32'h400);
        nxt(); smp();
        chk("rp4_if_pc", if_pc, 32'h404);

        // Address wrap.
        reset_to(32'hFFFF_FFFC);
        smp();
        chk("wr_imem_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_pc_next", pc_next, 32'h0);
        nxt(); smp();
        chk("wr_imem_addr2", imem_addr, 32'h0);
        nxt(); smp();
        chk("wr_if_pc0", if_pc, 32'hFFFF_FFFC);
        nxt(); smp();
        chk("wr_if_pc1", if_pc, 32'h0);
        chk("wr_if_instr1", if_instr, MAGIC);

        // Asynchronous reset between edges mid-stream.
        nxt(); nxt();
        smp();
        #2;
        pc_init = 32'h1000;
        clr     = 1'b1;
        #1;
        chk("ar_if_valid", 32'(if_valid), 32'd0);
        chk("ar_imem_req", 32'(imem_req), 32'd0);
        chk("ar_pc_en", 32'(pc_en), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        smp();
        chk("ar1_imem_addr", imem_addr, 32'h1000);
        chk("ar1_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("ar2_if_valid", 32'(if_valid), 32'd0);
        nxt(); smp();
        chk("ar3_if_pc", if_pc, 32'h1000);
        chk("ar3_if_instr", if_instr, 32'h1000 ^ MAGIC);
        nxt(); smp();
        chk("ar4_if_pc", if_pc, 32'h1004);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
